// File: rtl/hist_pkg.sv
// Shared definitions for the CI histogram read-out path: default widths,
// reader FSM states and the index-width helper.
package hist_pkg;

  localparam int WIDTH_DATA_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } hist_state_t;

  // Index width for n entries; never below 1 so a 2-bin reader still has a bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ci_hist_reader.sv
// Captures all histogram bins on i_start, clears the accumulator, streams the
// snapshot one bin per beat and reports the total on completion.
module ci_hist_reader
  import hist_pkg::*;
#(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int NUM_BINS = 2,
  localparam int WIDTH_IDX = idx_width(NUM_BINS),
  localparam int WIDTH_TOTAL = WIDTH_DATA + WIDTH_IDX
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [NUM_BINS*WIDTH_DATA-1:0] i_bins,
  input  logic                           i_ready,
  output logic                           o_clr,
  output logic                           o_valid,
  output logic [WIDTH_DATA-1:0]          o_data,
  output logic [WIDTH_IDX-1:0]           o_idx,
  output logic                           o_last,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [WIDTH_TOTAL-1:0]         o_total,
  output logic                           o_drop
);

  localparam logic [WIDTH_IDX-1:0] LAST_IDX = WIDTH_IDX'(NUM_BINS - 1);

  // Stream handshake: a beat moves on the rising edge where o_valid && i_ready.
  // o_valid is raised only in SEND and never falls before its beat moves;
  // o_data/o_idx/o_last stay fixed while the beat waits.

  hist_state_t                state_q;
  hist_state_t                state_d;
  logic [WIDTH_DATA-1:0]      snap_q [NUM_BINS];
  logic [WIDTH_IDX-1:0]       idx_q;
  logic [WIDTH_IDX-1:0]       idx_nxt;
  logic [WIDTH_DATA-1:0]      data_q;
  logic [WIDTH_TOTAL-1:0]     total_q;
  logic                       clr_q;
  logic                       drop_q;
  logic                       capture;
  logic                       xfer;
  logic                       is_last;

  assign capture = (state_q == IDLE) && i_start;
  assign xfer    = (state_q == SEND) && i_ready;
  assign is_last = (idx_q == LAST_IDX);
  assign idx_nxt = idx_q + WIDTH_IDX'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (capture) state_d = SEND;
      SEND: if (xfer && is_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot is taken only on the capture edge; later accumulator updates are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_BINS; k++) begin
        snap_q[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < NUM_BINS; k++) begin
        snap_q[k] <= i_bins[k*WIDTH_DATA +: WIDTH_DATA];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q <= '0;
    end else if (capture) begin
      idx_q <= '0;
    end else if (xfer && !is_last) begin
      idx_q <= idx_nxt;
    end
  end

  // Word register tracks snap_q[idx_q] so o_data is a flop, not a mux output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
    end else if (capture) begin
      data_q <= i_bins[0 +: WIDTH_DATA];
    end else if (xfer && !is_last) begin
      data_q <= snap_q[idx_nxt];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      total_q <= '0;
    end else if (capture) begin
      total_q <= '0;
    end else if (xfer) begin
      total_q <= total_q + WIDTH_TOTAL'(data_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clr_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      clr_q <= capture;
      if (i_start && (state_q != IDLE)) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign o_clr   = clr_q;
  assign o_valid = (state_q == SEND);
  assign o_data  = data_q;
  assign o_idx   = idx_q;
  assign o_last  = (state_q == SEND) && is_last;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);
  assign o_total = total_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_ci_hist_reader.sv
// Directed bench for ci_hist_reader: a 2-bin and a 4-bin instance share clock
// and reset; each step drives inputs, advances one edge and checks outputs.
module tb_ci_hist_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 2-bin instance
  logic        start2 = 1'b0;
  logic [47:0] bins2 = '0;
  logic        ready2 = 1'b0;
  logic        clr2, valid2, last2, busy2, done2, drop2;
  logic [23:0] data2;
  logic [0:0]  idx2;
  logic [24:0] total2;

  // 4-bin instance
  logic        start4 = 1'b0;
  logic [95:0] bins4 = '0;
  logic        ready4 = 1'b0;
  logic        clr4, valid4, last4, busy4, done4, drop4;
  logic [23:0] data4;
  logic [1:0]  idx4;
  logic [25:0] total4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ci_hist_reader #(.WIDTH_DATA(24), .NUM_BINS(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_bins(bins2), .i_ready(ready2),
    .o_clr(clr2), .o_valid(valid2), .o_data(data2), .o_idx(idx2), .o_last(last2),
    .o_busy(busy2), .o_done(done2), .o_total(total2), .o_drop(drop2)
  );

  ci_hist_reader #(.WIDTH_DATA(24), .NUM_BINS(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_bins(bins4), .i_ready(ready4),
    .o_clr(clr4), .o_valid(valid4), .o_data(data4), .o_idx(idx4), .o_last(last4),
    .o_busy(busy4), .o_done(done4), .o_total(total4), .o_drop(drop4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the 2-bin stream beat presented in the current cycle.
  task automatic check_beat2(input string tag, input logic [23:0] d, input logic [0:0] i,
                             input logic l);
    check({tag, "_valid"}, 32'(valid2), 32'd1);
    check({tag, "_data"}, 32'(data2), 32'(d));
    check({tag, "_idx"}, 32'(idx2), 32'(i));
    check({tag, "_last"}, 32'(last2), 32'(l));
  endtask

  task automatic check_beat4(input string tag, input logic [23:0] d, input logic [1:0] i,
                             input logic l);
    check({tag, "_valid"}, 32'(valid4), 32'd1);
    check({tag, "_data"}, 32'(data4), 32'(d));
    check({tag, "_idx"}, 32'(idx4), 32'(i));
    check({tag, "_last"}, 32'(last4), 32'(l));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 32'(valid2), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_clr", 32'(clr2), 32'd0);
    check("rst_done", 32'(done2), 32'd0);
    check("rst_drop", 32'(drop2), 32'd0);
    check("rst_data", 32'(data2), 32'd0);
    check("rst_total", 32'(total2), 32'd0);
    check("rst_total4", 32'(total4), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic frame: bin0=10, bin1=15, ready high
    bins2  = {24'd15, 24'd10};
    ready2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("f1_clr", 32'(clr2), 32'd1);
    check("f1_busy", 32'(busy2), 32'd1);
    check_beat2("f1_b0", 24'd10, 1'b0, 1'b0);
    tick();
    check("f1_clr_off", 32'(clr2), 32'd0);
    check_beat2("f1_b1", 24'd15, 1'b1, 1'b1);
    tick();
    check("f1_done", 32'(done2), 32'd1);
    check("f1_total", 32'(total2), 32'd25);
    check("f1_valid_done", 32'(valid2), 32'd0);
    tick();
    check("f1_done_off", 32'(done2), 32'd0);
    check("f1_busy_off", 32'(busy2), 32'd0);
    check("f1_total_hold", 32'(total2), 32'd25);
    check("f1_drop", 32'(drop2), 32'd0);

    // Stall 3 cycles on beat 0; bins change after capture
    ready2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    bins2  = {24'd99, 24'd99};
    check_beat2("st_c1", 24'd10, 1'b0, 1'b0);
    tick();
    check("st_clr_once", 32'(clr2), 32'd0);
    check_beat2("st_c2", 24'd10, 1'b0, 1'b0);
    tick();
    check_beat2("st_c3", 24'd10, 1'b0, 1'b0);
    ready2 = 1'b1;
    tick();
    check_beat2("st_b1", 24'd15, 1'b1, 1'b1);
    tick();
    check("st_done", 32'(done2), 32'd1);
    check("st_total", 32'(total2), 32'd25);
    tick();

    // i_start during SEND: dropped and flagged
    bins2  = {24'd15, 24'd10};
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check_beat2("dr_b0", 24'd10, 1'b0, 1'b0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("dr_clr", 32'(clr2), 32'd0);
    check("dr_drop", 32'(drop2), 32'd1);
    check_beat2("dr_b1", 24'd15, 1'b1, 1'b1);
    tick();
    check("dr_done", 32'(done2), 32'd1);
    check("dr_total", 32'(total2), 32'd25);
    check("dr_drop_done", 32'(drop2), 32'd1);
    tick();
    check("dr_idle", 32'(busy2), 32'd0);
    check("dr_drop_idle", 32'(drop2), 32'd1);

    // 4-bin frame: bin0=FFFFFF, bin1=2, bin2=1, bin3=0
    bins4  = {24'd0, 24'd1, 24'd2, 24'hFFFFFF};
    ready4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("n4_clr", 32'(clr4), 32'd1);
    check_beat4("n4_b0", 24'hFFFFFF, 2'd0, 1'b0);
    tick();
    check_beat4("n4_b1", 24'd2, 2'd1, 1'b0);
    tick();
    check_beat4("n4_b2", 24'd1, 2'd2, 1'b0);
    tick();
    check_beat4("n4_b3", 24'd0, 2'd3, 1'b1);
    tick();
    check("n4_done", 32'(done4), 32'd1);
    check("n4_total", 32'(total4), 32'h1000002);
    // start on the done cycle is dropped; a restart next cycle is accepted
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("n4_drop_on_done", 32'(drop4), 32'd1);
    check("n4_no_clr", 32'(clr4), 32'd0);
    check("n4_idle", 32'(busy4), 32'd0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("n4_restart_clr", 32'(clr4), 32'd1);
    check_beat4("n4_r_b0", 24'hFFFFFF, 2'd0, 1'b0);
    ready4 = 1'b0;

    // Reset mid-stream on beat idx1
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    check_beat2("rm_b1", 24'd15, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rm_valid", 32'(valid2), 32'd0);
    check("rm_busy", 32'(busy2), 32'd0);
    check("rm_data", 32'(data2), 32'd0);
    check("rm_drop", 32'(drop2), 32'd0);
    check("rm_valid4", 32'(valid4), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rm_no_done", 32'(done2), 32'd0);
    check("rm_no_clr", 32'(clr2), 32'd0);
    ready2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("rm_clr", 32'(clr2), 32'd1);
    check_beat2("rm_r_b0", 24'd10, 1'b0, 1'b0);
    tick();
    check_beat2("rm_r_b1", 24'd15, 1'b1, 1'b1);
    tick();
    check("rm_r_done", 32'(done2), 32'd1);
    check("rm_r_total", 32'(total2), 32'd25);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
